adc_uart_sequencer: RTL and testbench



---
 rtl/adc_uart_sequencer_pkg.sv | 31 +++
 rtl/adc_uart_sequencer_tick_divider.sv | 29 ++
 rtl/adc_uart_sequencer.sv | 133 +++++++++++++
 tb/tb_adc_uart_sequencer.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_uart_sequencer_pkg.sv
// Shared types and constants for the ADC scan / UART framing sequencer.
// ADC_SEQ_CHECKSUM_EN adds a fourth XOR checksum byte to every frame.
package adc_uart_sequencer_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WAIT_ADC,
    S_SEND_HDR,
    S_SEND_MSB,
    S_SEND_LSB,
`ifdef ADC_SEQ_CHECKSUM_EN
    S_SEND_CRC,
`endif
    S_NEXT
  } state_e;

  localparam logic [2:0]  HEADER_TAG   = 3'b101;
  localparam logic [15:0] TIMEOUT_DATA = 16'hFFFF;

`ifdef ADC_SEQ_CHECKSUM_EN
  localparam int FRAME_BYTES = 4;
`else
  localparam int FRAME_BYTES = 3;
`endif

  function automatic logic [7:0] header_byte(input logic to_flag, input logic [3:0] ch);
    return {HEADER_TAG, to_flag, ch};
  endfunction

endpackage

// File: rtl/adc_uart_sequencer_tick_divider.sv
// Free-running sample-tick divider; held at zero while enable is low.
module tick_divider #(
  parameter int TICK_DIV = 10
) (
  input  logic clk_in,
  input  logic reset,
  input  logic enable,
  output logic tick
);

  localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (!enable || cnt_q == LAST) cnt_d = '0;
    else                          cnt_d = cnt_q + 1'b1;
  end

  assign tick = enable && (cnt_q == LAST);

  always_ff @(posedge clk_in) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/adc_uart_sequencer.sv
// Periodic ADC scan controller: converts every channel per tick and ships each result
// as a framed byte stream over valid/ready. Optional macro: ADC_SEQ_CHECKSUM_EN.
module adc_uart_sequencer
  import adc_uart_sequencer_pkg::*;
#(
  parameter int CLOCK       = 50000000,
  parameter int SAMPLE_RATE = 100,
  parameter int NUM_CH      = 4,
  parameter int ADC_BITS    = 12,
  parameter int ADC_TIMEOUT = 1000
) (
  input  logic                clk_in,
  input  logic                reset,
  input  logic                enable,
  output logic                adc_start,
  output logic [3:0]          adc_ch,
  input  logic                adc_done,
  input  logic [ADC_BITS-1:0] adc_data,
  output logic [7:0]          tx_data,
  output logic                tx_valid,
  input  logic                tx_ready,
  output logic                busy,
  output logic                overrun
);

  localparam int TICK_DIV = CLOCK / SAMPLE_RATE;
  localparam int TW = (ADC_TIMEOUT > 1) ? $clog2(ADC_TIMEOUT) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'(ADC_TIMEOUT - 1);
  localparam logic [3:0]    LAST_CH = 4'(NUM_CH - 1);

  state_e        state_q, state_d;
  logic [3:0]    ch_q, ch_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic          gap_q, gap_d;
  logic          overrun_q, overrun_d;
  logic [15:0]   data_q;
  logic          to_flag_q;
  logic          tick, xfer, to_hit;
  logic [7:0]    hdr_byte;

  tick_divider #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk_in (clk_in),
    .reset  (reset),
    .enable (enable),
    .tick   (tick)
  );

  assign xfer     = tx_valid && tx_ready;
  assign to_hit   = (to_cnt_q == TO_LAST);
  assign hdr_byte = header_byte(to_flag_q, ch_q);

  always_ff @(posedge clk_in) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:     if (tick) state_d = S_START;
      S_START:    state_d = S_WAIT_ADC;
      S_WAIT_ADC: if (adc_done || to_hit) state_d = S_SEND_HDR;
      S_SEND_HDR: if (xfer) state_d = S_SEND_MSB;
      S_SEND_MSB: if (xfer) state_d = S_SEND_LSB;
`ifdef ADC_SEQ_CHECKSUM_EN
      S_SEND_LSB: if (xfer) state_d = S_SEND_CRC;
      S_SEND_CRC: if (xfer) state_d = S_NEXT;
`else
      S_SEND_LSB: if (xfer) state_d = S_NEXT;
`endif
      S_NEXT:     state_d = (ch_q == LAST_CH) ? S_IDLE : S_START;
      default:    state_d = S_IDLE;
    endcase
  end

  // gap_q masks tx_valid for the cycle after each transfer inside a frame
  always_comb begin
    ch_d      = ch_q;
    to_cnt_d  = to_cnt_q;
    gap_d     = xfer && (state_d != S_NEXT);
    overrun_d = overrun_q | (tick && state_q != S_IDLE);
    if (state_q == S_IDLE && tick)           ch_d = '0;
    if (state_q == S_NEXT && ch_q != LAST_CH) ch_d = ch_q + 1'b1;
    if (state_q == S_START)                  to_cnt_d = '0;
    if (state_q == S_WAIT_ADC)               to_cnt_d = to_cnt_q + 1'b1;
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      ch_q      <= '0;
      to_cnt_q  <= '0;
      gap_q     <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      ch_q      <= ch_d;
      to_cnt_q  <= to_cnt_d;
      gap_q     <= gap_d;
      overrun_q <= overrun_d;
    end
  end

  // adc_done takes priority over a timeout landing in the same cycle
  always_ff @(posedge clk_in) begin
    if (state_q == S_WAIT_ADC) begin
      if (adc_done) begin
        data_q    <= 16'(adc_data);
        to_flag_q <= 1'b0;
      end else if (to_hit) begin
        data_q    <= TIMEOUT_DATA;
        to_flag_q <= 1'b1;
      end
    end
  end

  always_comb begin
    adc_start = (state_q == S_START);
    adc_ch    = ch_q;
    busy      = (state_q != S_IDLE);
    overrun   = overrun_q;
    tx_valid  = 1'b0;
    tx_data   = '0;
    unique case (state_q)
      S_SEND_HDR: begin tx_valid = !gap_q; tx_data = hdr_byte;     end
      S_SEND_MSB: begin tx_valid = !gap_q; tx_data = data_q[15:8]; end
      S_SEND_LSB: begin tx_valid = !gap_q; tx_data = data_q[7:0];  end
`ifdef ADC_SEQ_CHECKSUM_EN
      S_SEND_CRC: begin tx_valid = !gap_q; tx_data = hdr_byte ^ data_q[15:8] ^ data_q[7:0]; end
`endif
      default: ;
    endcase
  end

endmodule

// File: tb/tb_adc_uart_sequencer.sv
// Directed bench for adc_uart_sequencer (TICK_DIV=10, 2 channels, timeout 8).
// Frame expectations follow ADC_SEQ_CHECKSUM_EN when the macro is defined.
module tb_adc_uart_sequencer;
  import adc_uart_sequencer_pkg::*;

  logic        clk_in = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        adc_start;
  logic [3:0]  adc_ch;
  logic        adc_done = 1'b0;
  logic [11:0] adc_data = '0;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b1;
  logic        busy;
  logic        overrun;

  int n_cmp = 0;
  int n_err = 0;

  adc_uart_sequencer #(
    .CLOCK(1000), .SAMPLE_RATE(100), .NUM_CH(2), .ADC_BITS(12), .ADC_TIMEOUT(8)
  ) dut (
    .clk_in(clk_in), .reset(reset), .enable(enable),
    .adc_start(adc_start), .adc_ch(adc_ch), .adc_done(adc_done), .adc_data(adc_data),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .busy(busy), .overrun(overrun)
  );

  always #5 clk_in = ~clk_in;

  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  // Monitor/ADC model state, owned by the negedge process below
  logic [7:0]  bytes_q[$];
  logic [11:0] chan_val[2] = '{12'hABC, 12'h123};
  logic [1:0]  noresp_mask = 2'b00;
  int          start_cyc[2] = '{0, 0};
  int          n_starts = 0;
  int          last_start = 0;
  int          hdr_lat = -1;
  bit          hdr_seen = 1'b1;
  int          pend = 0;
  logic        resp_ch = 1'b0;
  bit          prev_xfer = 1'b0, prev_valid = 1'b0, prev_reset = 1'b1;
  int          b2b_cnt = 0, drop_cnt = 0;

  initial forever begin
    @(negedge clk_in);
    if (reset) begin
      pend     = 0;
      adc_done = 1'b0;
    end else begin
      adc_done = 1'b0;
      if (adc_start) begin
        n_starts++;
        last_start = cyc;
        hdr_seen   = 1'b0;
        start_cyc[adc_ch[0]] = cyc;
        resp_ch = adc_ch[0];
        pend    = noresp_mask[adc_ch[0]] ? 0 : 3;
      end else if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          adc_done = 1'b1;
          adc_data = chan_val[resp_ch];
        end
      end
      if (tx_valid && !hdr_seen) begin
        hdr_lat  = cyc - last_start;
        hdr_seen = 1'b1;
      end
      if (tx_valid && prev_xfer) b2b_cnt++;
      if (prev_valid && !prev_xfer && !tx_valid && !prev_reset) drop_cnt++;
      if (tx_valid && tx_ready) bytes_q.push_back(tx_data);
    end
    prev_xfer  = tx_valid && tx_ready;
    prev_valid = tx_valid;
    prev_reset = reset;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, observed no finish, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk_in);
      #1;
    end
  endtask

  task automatic to_cycle(input int target);
    while (cyc < target) step(1);
  endtask

  task automatic wait_busy(input logic lvl, input int maxc, input string tag);
    int k = 0;
    while (busy !== lvl && k < maxc) begin
      step(1);
      k++;
    end
    check(tag, 32'(busy), 32'(lvl));
  endtask

  task automatic run_scan(input string tag);
    enable = 1'b1;
    wait_busy(1'b1, 30, {tag, "_busy_rise"});
    enable = 1'b0;
    wait_busy(1'b0, 200, {tag, "_busy_fall"});
  endtask

  task automatic check_bytes(input string tag, input logic [7:0] exp[$]);
    check({tag, "_count"}, 32'(bytes_q.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size() && i < bytes_q.size(); i++)
      check($sformatf("%s_byte%0d", tag, i), 32'(bytes_q[i]), 32'(exp[i]));
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_adc_start"}, 32'(adc_start), 32'd0);
    check({tag, "_adc_ch"},    32'(adc_ch),    32'd0);
    check({tag, "_tx_data"},   32'(tx_data),   32'd0);
    check({tag, "_tx_valid"},  32'(tx_valid),  32'd0);
    check({tag, "_busy"},      32'(busy),      32'd0);
    check({tag, "_overrun"},   32'(overrun),   32'd0);
  endtask

  initial begin
    logic [7:0] exp_scan[$];
    logic [7:0] exp_to[$];
    int frame_cyc;
    int e0, s0, k;

`ifdef ADC_SEQ_CHECKSUM_EN
    exp_scan  = '{8'hA0, 8'h0A, 8'hBC, 8'h16, 8'hA1, 8'h01, 8'h23, 8'h83};
    exp_to    = '{8'hA0, 8'h0A, 8'hBC, 8'h16, 8'hB1, 8'hFF, 8'hFF, 8'hB1};
    frame_cyc = 12;
`else
    exp_scan  = '{8'hA0, 8'h0A, 8'hBC, 8'hA1, 8'h01, 8'h23};
    exp_to    = '{8'hA0, 8'h0A, 8'hBC, 8'hB1, 8'hFF, 8'hFF};
    frame_cyc = 10;
`endif

    // Reset state
    step(3);
    check_idle_outputs("reset");
    reset = 1'b0;
    step(1);

    // Basic two-channel scan, tx_ready held high
    bytes_q.delete();
    run_scan("scan");
    check_bytes("scan", exp_scan);
    check("scan_overrun", 32'(overrun), 32'd0);
    check("scan_frame_cycles", 32'(start_cyc[1] - start_cyc[0]), 32'(frame_cyc));
    check("scan_hdr_latency", 32'(hdr_lat), 32'd4);

    // Backpressure on the first header
    bytes_q.delete();
    tx_ready = 1'b0;
    enable   = 1'b1;
    wait_busy(1'b1, 30, "bp_busy_rise");
    enable = 1'b0;
    k = 0;
    while (tx_valid !== 1'b1 && k < 30) begin
      step(1);
      k++;
    end
    for (int i = 0; i < 5; i++) begin
      check($sformatf("bp_valid_c%0d", i), 32'(tx_valid), 32'd1);
      check($sformatf("bp_data_c%0d", i),  32'(tx_data),  32'hA0);
      step(1);
    end
    check("bp_no_early_xfer", 32'(bytes_q.size()), 32'd0);
    tx_ready = 1'b1;
    wait_busy(1'b0, 200, "bp_busy_fall");
    check_bytes("bp", exp_scan);

    // ADC silent on ch1 -> timeout frame
    bytes_q.delete();
    noresp_mask = 2'b10;
    run_scan("tmo");
    check_bytes("tmo", exp_to);
    check("tmo_hdr_latency", 32'(hdr_lat), 32'd9);
    check("tmo_idle", 32'(busy), 32'd0);
    noresp_mask = 2'b00;

    // Ticks keep coming while a scan is longer than TICK_DIV
    bytes_q.delete();
    s0 = n_starts;
    enable = 1'b1;
    e0 = cyc;
    to_cycle(e0 + 18);
    check("ovr_before", 32'(overrun), 32'd0);
    to_cycle(e0 + 20);
    check("ovr_set", 32'(overrun), 32'd1);
    to_cycle(e0 + 40);
    check("ovr_second_scan_start", 32'(adc_start), 32'd1);
    enable = 1'b0;
    wait_busy(1'b0, 200, "ovr_busy_fall");
    check("ovr_starts", 32'(n_starts - s0), 32'd4);
    check("ovr_bytes", 32'(bytes_q.size()), 32'(4 * FRAME_BYTES));
    check("ovr_sticky", 32'(overrun), 32'd1);

    // Reset while the MSB byte is presented
    bytes_q.delete();
    enable = 1'b1;
    wait_busy(1'b1, 30, "rst_busy_rise");
    enable = 1'b0;
    k = 0;
    while (!(tx_valid === 1'b1 && bytes_q.size() == 1) && k < 40) begin
      step(1);
      k++;
    end
    check("rst_in_msb", 32'(tx_data), 32'h0A);
    reset = 1'b1;
    step(1);
    check_idle_outputs("rst_mid");
    reset = 1'b0;
    step(1);

    // First tick after reset, then enable dropped mid-scan
    bytes_q.delete();
    s0 = n_starts;
    enable = 1'b1;
    e0 = cyc;
    k = 0;
    while (adc_start !== 1'b1 && k < 20) begin
      step(1);
      k++;
    end
    check("post_rst_tick_latency", 32'(cyc - e0), 32'd10);
    check("post_rst_ch", 32'(adc_ch), 32'd0);
    enable = 1'b0;
    wait_busy(1'b0, 200, "post_rst_busy_fall");
    check_bytes("post_rst", exp_scan);
    step(40);
    check("post_rst_no_more_scans", 32'(n_starts - s0), 32'd2);
    check("post_rst_idle", 32'(busy), 32'd0);

    check("no_back_to_back_valid", 32'(b2b_cnt), 32'd0);
    check("no_valid_drop", 32'(drop_cnt), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
